// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART byte receiver with mid-bit 3-sample majority voting
module uart_byte_rx #(
    parameter int DIV0 = 20833,
    parameter int DIV1 = 10416,
    parameter int DIV2 = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_rx,
    input  logic [2:0] set_baud,
    input  logic       rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       uart_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [15:0] P0 = 16'(DIV0);
    localparam logic [15:0] P1 = 16'(DIV1);
    localparam logic [15:0] P2 = 16'(DIV2);

    logic        r_rx_m;
    logic        r_rx_s;
    logic        r_rx_d;
    logic [1:0]  r_state;
    logic [15:0] r_period;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic        r_s0;
    logic        r_s1;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_done;
    logic        r_err;

    logic [15:0] w_half;
    logic [15:0] w_baud_p;
    logic        w_at_lo;
    logic        w_at_mid;
    logic        w_at_hi;
    logic        w_at_end;
    logic        w_maj;
    logic        w_fall;

    always_comb begin
        w_baud_p = P2;
        case (set_baud)
            3'd0:    w_baud_p = P0;
            3'd1:    w_baud_p = P1;
            default: w_baud_p = P2;
        endcase
    end

    assign w_half   = {1'b0, r_period[15:1]};
    assign w_at_lo  = (r_cnt == w_half - 16'd1);
    assign w_at_mid = (r_cnt == w_half);
    assign w_at_hi  = (r_cnt == w_half + 16'd1);
    assign w_at_end = (r_cnt == r_period - 16'd1);
    // Third sample is the live synchronized value at H+1.
    assign w_maj    = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
    assign w_fall   = r_rx_d & ~r_rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
            r_rx_d <= 1'b1;
        end else begin
            r_rx_m <= rx;
            r_rx_s <= r_rx_m;
            r_rx_d <= r_rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_period  <= 16'd0;
            r_cnt     <= 16'd0;
            r_bit_idx <= 3'd0;
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
            r_shift   <= 8'd0;
            r_data    <= 8'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (!en_rx) begin
                r_state   <= S_IDLE;
                r_cnt     <= 16'd0;
                r_bit_idx <= 3'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_fall) begin
                            r_state  <= S_START;
                            r_cnt    <= 16'd0;
                            r_period <= w_baud_p;
                        end
                    end
                    default: begin
                        r_cnt <= w_at_end ? 16'd0 : r_cnt + 16'd1;
                        if (w_at_lo)  r_s0 <= r_rx_s;
                        if (w_at_mid) r_s1 <= r_rx_s;
                        case (r_state)
                            S_START: begin
                                if (w_at_hi && w_maj) begin
                                    r_state <= S_IDLE;
                                    r_cnt   <= 16'd0;
                                end else if (w_at_end) begin
                                    r_state   <= S_DATA;
                                    r_bit_idx <= 3'd0;
                                end
                            end
                            S_DATA: begin
                                if (w_at_hi) r_shift[r_bit_idx] <= w_maj;
                                if (w_at_end) begin
                                    if (r_bit_idx == 3'd7) r_state <= S_STOP;
                                    r_bit_idx <= r_bit_idx + 3'd1;
                                end
                            end
                            S_STOP: begin
                                // Leave at mid-stop so a back-to-back start edge is not missed.
                                if (w_at_hi) begin
                                    r_state <= S_IDLE;
                                    r_cnt   <= 16'd0;
                                    if (w_maj) begin
                                        r_data <= r_shift;
                                        r_done <= 1'b1;
                                    end else begin
                                        r_err <= 1'b1;
                                    end
                                end
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                endcase
            end
        end
    end

    assign data_byte  = r_data;
    assign rx_done    = r_done;
    assign frame_err  = r_err;
    assign uart_state = (r_state != S_IDLE) | r_done | r_err;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - scoreboard bench for uart_byte_rx
`timescale 1ns/1ps
module tb_uart_byte_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_rx;
    logic [2:0] set_baud;
    logic       rx;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       uart_state;

    uart_byte_rx #(.DIV0(209), .DIV1(105), .DIV2(53)) dut (
        .clk(clk), .rst_n(rst_n), .en_rx(en_rx), .set_baud(set_baud), .rx(rx),
        .data_byte(data_byte), .rx_done(rx_done), .frame_err(frame_err),
        .uart_state(uart_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    logic [7:0] last_good = 8'd0;
    int         n_checks = 0;
    int         n_errs = 0;
    logic       prev_pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int p_of(input logic [2:0] code);
        return (code == 3'd0) ? 209 : (code == 3'd1) ? 105 : 53;
    endfunction

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rx_done || frame_err) begin
            check("pulse_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
            check("pulse_single_cycle", {31'd0, prev_pulse}, 32'd0);
            if (q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_pulse: got done=%0d err=%0d expected none", rx_done, frame_err);
            end else begin
                e = q.pop_front();
                check("pulse_kind", {31'd0, frame_err}, {31'd0, e.err});
                if (rx_done) begin
                    check("data_byte", {24'd0, data_byte}, {24'd0, e.data});
                    last_good = e.data;
                end else begin
                    check("data_held_on_err", {24'd0, data_byte}, {24'd0, last_good});
                end
            end
        end
        prev_pulse = rx_done | frame_err;
    end

    task automatic drive_bit(input logic v, input int len, input bit spike);
        rx = v;
        if (spike) begin
            repeat (len / 2 - 1) @(posedge clk);
            #1 rx = ~v;
            @(posedge clk);
            #1 rx = v;
            repeat (len - len / 2) @(posedge clk);
            #1;
        end else begin
            repeat (len) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int len, input logic stop_v,
                              input bit expect_it, input bit spikes, input bit scramble);
        exp_t e;
        if (expect_it) begin
            e.err  = ~stop_v;
            e.data = b;
            q.push_back(e);
        end
        drive_bit(1'b0, len, 1'b0);
        if (scramble) set_baud = 3'($urandom_range(0, 7));
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i], len, spikes);
            if (expect_it && i == 0) check("busy_mid_frame", {31'd0, uart_state}, 32'd1);
        end
        drive_bit(stop_v, len, 1'b0);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int   p;
        bit   ok;
        rst_n = 1'b0; en_rx = 1'b1; set_baud = 3'd2; rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_byte", {24'd0, data_byte}, 32'd0);
        check("rst_rx_done", {31'd0, rx_done}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_uart_state", {31'd0, uart_state}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(10);

        send_frame(8'hA5, 53, 1'b1, 1, 0, 0);
        idle(20);
        check("idle_after_a5", {31'd0, uart_state}, 32'd0);

        set_baud = 3'd0;
        send_frame(8'h00, 209, 1'b1, 1, 0, 0);
        send_frame(8'hFF, 209, 1'b1, 1, 0, 0);
        send_frame(8'h3C, 209, 1'b1, 1, 0, 0);
        idle(120);

        set_baud = 3'd2;
        send_frame(8'h55, 53, 1'b0, 1, 0, 0);
        idle(20);
        send_frame(8'h81, 53, 1'b1, 1, 0, 0);
        idle(40);

        drive_bit(1'b0, 10, 1'b0);
        idle(40);
        check("glitch_idle", {31'd0, uart_state}, 32'd0);

        send_frame(8'h96, 53, 1'b1, 1, 1, 0);
        idle(40);

        fork
            send_frame(8'h3C, 53, 1'b1, 0, 0, 0);
            begin
                repeat (5 * 53 + 26) @(posedge clk);
                #1 en_rx = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("en_rx_off_state", {31'd0, uart_state}, 32'd0);
            end
        join
        idle(10);
        en_rx = 1'b1;
        idle(10);

        fork
            send_frame(8'hFF, 53, 1'b1, 0, 0, 0);
            begin
                repeat (3 * 53 + 20) @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                last_good = 8'd0;
                @(negedge clk);
                check("rst_mid_state", {31'd0, uart_state}, 32'd0);
                check("rst_mid_data", {24'd0, data_byte}, 32'd0);
            end
        join
        idle(20);

        send_frame(8'h7E, 53, 1'b1, 1, 0, 0);
        idle(20);
        send_frame(8'h7E, 55, 1'b1, 1, 0, 0);
        idle(20);
        send_frame(8'h7E, 51, 1'b1, 1, 0, 0);
        idle(20);

        for (int k = 0; k < 10; k++) begin
            set_baud = 3'($urandom_range(0, 7));
            p = p_of(set_baud);
            send_frame(8'($urandom_range(0, 255)), p, logic'($urandom_range(0, 3) != 0), 1, 0, 1);
            idle($urandom_range(4, 30));
        end

        ok = 0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(posedge clk);
            if (q.size() == 0) ok = 1;
        end
        check("scoreboard_drained", q.size(), 32'd0);
        @(negedge clk);
        check("final_idle", {31'd0, uart_state}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- UART receiver for 8N1 frames: idle-high line, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Recovers one byte per frame using a per-bit cycle counter with mid-bit 3-sample majority voting.
- Flags framing errors.
- Sits between the board RX pin and byte-level consumers. Baud selection uses the same 3-bit `set_baud` code as the UART byte transmitter, so the two loop back directly.

Parameters:
- DIV0, 20833, clock cycles per bit for set_baud=0 (2400 baud @ 50 MHz)
- DIV1, 10416, clock cycles per bit for set_baud=1 (4800 baud)
- DIV2, 5208, clock cycles per bit for set_baud=2 and for codes 3-7 (9600 baud)
- Constraint: every DIVn >= 8. Simulation overrides DIV0/1/2 with 209/105/53.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- en_rx  in  1  receiver enable; 0 forces idle
- set_baud  in  3  baud select (0,1,2; 3-7 act as 2)
- rx  in  1  asynchronous serial input, idle high
- data_byte  out  8  last correctly framed byte, registered
- rx_done  out  1  one-cycle pulse: new valid byte on data_byte
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- uart_state  out  1  1 while a frame is in progress (START/DATA/STOP)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - data_byte=0, rx_done=0, frame_err=0, uart_state=0, state=IDLE, counters=0.
  - Both synchronizer flops and the edge-detect flop are set to 1.
  - Reset mid-frame abandons the frame with no pulses.
- Input synchronizer: rx passes through 2 flops to give rx_s. Edge detect compares rx_s with its 1-cycle-delayed copy.
- Bit period P:
  - P is latched from set_baud on start detection.
  - A set_baud change mid-frame has no effect until the next frame.
  - Let H = P/2 (integer floor).
- Bit counter cnt: counts 0..P-1 within each bit, then wraps to 0.
- Sampling:
  - rx_s is sampled at cnt = H-1, H and H+1.
  - The bit value is the majority of the 3 samples, decided at cnt = H+1.
- FSM states and transitions:
  - IDLE: uart_state=0. A falling edge on rx_s with en_rx=1 moves to START, sets cnt=0 and latches P.
  - START: if the start majority is 1, it is a false start: go to IDLE, no pulses. Otherwise, at cnt=P-1 go to DATA with bit_idx=0.
  - DATA: the majority bit is shifted into the shift register at position bit_idx (LSB first). At cnt=P-1, bit_idx increments; after bit_idx=7 go to STOP.
  - STOP: at cnt=H+1, evaluate the stop majority.
    - If 1: data_byte <= shift register and rx_done=1 for the next cycle only.
    - If 0: frame_err=1 for the next cycle only; data_byte is unchanged.
    - In both cases go to IDLE in the same cycle. The early exit lets the receiver catch back-to-back frames and tolerate about ±(H-1)/(10P) baud mismatch.
- rx_done and frame_err are never both high and never high for 2 consecutive cycles from one frame.
- uart_state is 1 from the cycle after start detection up to and including the cycle rx_done or frame_err is asserted.
- After a framing error the FSM is in IDLE. A 0 line produces no falling edge, so no new frame starts until rx_s returns to 1 and falls again.
- en_rx=0 at any clk edge:
  - State goes to IDLE and counters clear.
  - No pulses are generated; uart_state=0.
  - data_byte is held.
  - The synchronizer keeps running.
- Latency: rx_done rises 2 (sync) + 9P + H + 2 cycles after the rx falling edge of the start bit, within ±1 cycle of sync uncertainty.

Test Plan:
- Sim DIV2=53, set_baud=2, send 0xA5 with 53-cycle bits -> exactly one rx_done pulse, data_byte=0xA5, frame_err never 1, uart_state returns to 0.
- Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap, set_baud=0 (P=209) -> three rx_done pulses with data_byte 0x00, 0xFF, 0x3C respectively.
- 0x55 frame whose stop bit is driven 0 -> frame_err pulses once, rx_done stays 0, data_byte keeps its previous value; line then returns to 1 and a frame 0x81 is received correctly.
- 10-cycle low glitch on idle line, P=53 -> no rx_done/frame_err, uart_state returns to 0 by cnt=H+2.
- Single-cycle inverted spike at each data-bit midpoint of 0x96 -> majority rejects spikes, data_byte=0x96.
- Deassert en_rx during bit 4 of a frame, and separately pulse rst_n low during DATA -> no pulses, uart_state=0 next cycle; after reset data_byte=0. The next full frame 0x7E is received correctly, including when it is sent with a ±3% baud error.
